// File: rtl/sync_timing_checker.sv
// sync_timing_checker
//   Receive-side partner of the timing generator. Watches one sync_line/sync_frame pair,
//   measures the line period (clocks between line edges) and the lines per frame, checks
//   both against expected values, and reports mismatches, an error count and lock status.
//
// Ports
//   clk_gen      in   1             system clock, rising edge
//   reset        in   1             asynchronous active-low reset
//   sync_line    in   1             line sync, active high, same clock domain
//   sync_frame   in   1             frame sync, active high, same clock domain
//   line_period  out  bit_cnt_pix   last measured line period in clocks
//   frame_lines  out  bit_cnt_line  last measured lines per frame
//   err_line     out  1             1-cycle pulse: bad line period or line timeout
//   err_frame    out  1             1-cycle pulse: bad line count per frame
//   locked       out  1             lock_frames consecutive good frames seen
//   err_count    out  8             saturating count of cycles with any error pulse
module sync_timing_checker #(
  parameter int unsigned bit_cnt_pix     = 12,
  parameter int unsigned bit_cnt_line    = 12,
  parameter int unsigned exp_line_period = 800,
  parameter int unsigned exp_frame_lines = 525,
  parameter int unsigned lock_frames     = 4
) (
  input  logic                    clk_gen,
  input  logic                    reset,
  input  logic                    sync_line,
  input  logic                    sync_frame,
  output logic [bit_cnt_pix-1:0]  line_period,
  output logic [bit_cnt_line-1:0] frame_lines,
  output logic                    err_line,
  output logic                    err_frame,
  output logic                    locked,
  output logic [7:0]              err_count
);

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  localparam int unsigned GoodW = $clog2(lock_frames + 1);

  localparam logic [bit_cnt_pix-1:0]  PixOne    = bit_cnt_pix'(1);
  localparam logic [bit_cnt_pix-1:0]  PixMax    = '1;
  localparam logic [bit_cnt_pix-1:0]  PixPre    = PixMax - PixOne;
  localparam logic [bit_cnt_pix:0]    MeasOne   = (bit_cnt_pix + 1)'(1);
  localparam logic [bit_cnt_pix:0]    ExpPeriod = (bit_cnt_pix + 1)'(exp_line_period);
  localparam logic [bit_cnt_line-1:0] LineOne   = bit_cnt_line'(1);
  localparam logic [bit_cnt_line-1:0] LineMax   = '1;
  localparam logic [bit_cnt_line-1:0] ExpLines  = bit_cnt_line'(exp_frame_lines);
  localparam logic [GoodW-1:0]        GoodOne   = GoodW'(1);
  localparam logic [GoodW-1:0]        LockCnt   = GoodW'(lock_frames);

  // Input sampling and edge detection
  logic line_s1_q, line_s2_q, frame_s1_q, frame_s2_q;
  logic line_edge, frame_edge;

  // Measurement and status state
  logic [bit_cnt_pix-1:0]  pix_cnt_q, pix_cnt_d;
  logic [bit_cnt_line-1:0] line_cnt_q, line_cnt_d;
  logic [bit_cnt_pix-1:0]  line_period_q, line_period_d;
  logic [bit_cnt_line-1:0] frame_lines_q, frame_lines_d;
  logic                    meas_valid_q, meas_valid_d;
  logic                    err_line_q, err_line_d;
  logic                    err_frame_q, err_frame_d;
  logic                    locked_q, locked_d;
  logic [7:0]              err_count_q, err_count_d;
  logic [1:0]              state_q, state_d;
  logic [GoodW-1:0]        good_cnt_q, good_cnt_d;
  logic                    err_seen_q, err_seen_d;

  logic [bit_cnt_pix:0]    measured;
  logic [GoodW-1:0]        good_inc;
  logic                    checking, timeout, line_bad, frame_bad, any_err;

  assign line_edge  = line_s1_q & ~line_s2_q;
  assign frame_edge = frame_s1_q & ~frame_s2_q;

  // One extra bit so a saturated counter cannot wrap the measured period to zero.
  assign measured = {1'b0, pix_cnt_q} + MeasOne;
  assign good_inc = good_cnt_q + GoodOne;

  assign checking  = (state_q != StSearch);
  // Fires only on the step into all-ones, so a stalled line reports exactly once.
  assign timeout   = checking && !line_edge && (pix_cnt_q == PixPre);
  assign line_bad  = checking && line_edge && meas_valid_q && (measured != ExpPeriod);
  assign frame_bad = checking && frame_edge && (line_cnt_q != ExpLines);
  assign any_err   = err_line_d | err_frame_d;

  assign err_line_d  = line_bad | timeout;
  assign err_frame_d = frame_bad;

  // Counters and measurements
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_period_d = line_period_q;
    frame_lines_d = frame_lines_q;
    meas_valid_d  = meas_valid_q;
    err_count_d   = err_count_q;

    if (line_edge) begin
      pix_cnt_d = '0;
    end else if (pix_cnt_q != PixMax) begin
      pix_cnt_d = pix_cnt_q + PixOne;
    end

    // The first edge after (re)entering search only opens a measurement window.
    if (line_edge) begin
      meas_valid_d = 1'b1;
      if (meas_valid_q) begin
        line_period_d = measured[bit_cnt_pix-1:0];
      end
    end
    if (timeout) begin
      meas_valid_d = 1'b0;
    end

    // A line edge coincident with a frame edge is line 1 of the new frame.
    if (frame_edge) begin
      frame_lines_d = line_cnt_q;
      line_cnt_d    = line_edge ? LineOne : '0;
    end else if (line_edge && (line_cnt_q != LineMax)) begin
      line_cnt_d = line_cnt_q + LineOne;
    end

    if (any_err && (err_count_q != 8'hff)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Lock FSM
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_seen_d = err_seen_q;
    locked_d   = locked_q;

    case (state_q)
      StSearch: begin
        if (frame_edge) begin
          state_d    = StAcquire;
          good_cnt_d = '0;
          err_seen_d = 1'b0;
        end
      end
      StAcquire, StLocked: begin
        if (timeout) begin
          state_d    = StSearch;
          good_cnt_d = '0;
          err_seen_d = 1'b0;
          locked_d   = 1'b0;
        end else if (any_err) begin
          state_d    = StAcquire;
          good_cnt_d = '0;
          locked_d   = 1'b0;
          // An error landing on a frame edge belongs to the frame that just closed.
          err_seen_d = ~frame_edge;
        end else if (frame_edge) begin
          err_seen_d = 1'b0;
          if ((state_q == StAcquire) && !err_seen_q) begin
            good_cnt_d = good_inc;
            if (good_inc == LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d    = StSearch;
        good_cnt_d = '0;
        err_seen_d = 1'b0;
        locked_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_gen or negedge reset) begin
    if (!reset) begin
      line_s1_q     <= 1'b0;
      line_s2_q     <= 1'b0;
      frame_s1_q    <= 1'b0;
      frame_s2_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
      meas_valid_q  <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
      state_q       <= StSearch;
      good_cnt_q    <= '0;
      err_seen_q    <= 1'b0;
    end else begin
      line_s1_q     <= sync_line;
      line_s2_q     <= line_s1_q;
      frame_s1_q    <= sync_frame;
      frame_s2_q    <= frame_s1_q;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_period_q <= line_period_d;
      frame_lines_q <= frame_lines_d;
      meas_valid_q  <= meas_valid_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      err_seen_q    <= err_seen_d;
    end
  end

  assign line_period = line_period_q;
  assign frame_lines = frame_lines_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;
  assign locked      = locked_q;
  assign err_count   = err_count_q;

endmodule
